// File: rtl/acc_mac_ctrl.sv
// Bus-mapped 16-tap signed MAC engine: IDLE -> RUN (one MAC per cycle) -> DONE, result saturated to 16 bits.
// Read data is registered (1-cycle latency); buffer/LEN writes are accepted only in IDLE; no backpressure.
module acc_mac_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        iACC_en,
  output logic        oACC_done,
  input  logic        iBusWrite,
  input  logic        iBusRead,
  input  logic [7:0]  iBusAddr,
  input  logic [15:0] iBusWData,
  output logic [15:0] oBusRData,
  output logic        oBusy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, nextState;
  logic signed [15:0] aBuf [16];
  logic signed [15:0] wBuf [16];
  logic [4:0]         lenReg, runCnt, lenWr;
  logic [3:0]         idx;
  logic signed [31:0] acc, prod, accNext;
  logic [15:0]        result, satVal, rdMux;
  logic               satFlag, satNext, prevEn, armed;
  logic               start, macEn, finish, wrIdle;

  assign oACC_done = (state == DONE);
  assign oBusy     = (state == RUN);
  assign wrIdle    = iBusWrite && (state == IDLE);
  assign lenWr     = (iBusWData[4:0] > 5'd16) ? 5'd16 : iBusWData[4:0];

  // armed blocks a start until iACC_en has been seen low at least once since reset
  always_comb begin
    start   = (state == IDLE) && iACC_en && !prevEn && armed;
    macEn   = (state == RUN) && iACC_en && (runCnt != 5'd0);
    finish  = (state == RUN) && iACC_en && (runCnt <= 5'd1);
    prod    = 32'(aBuf[idx]) * 32'(wBuf[idx]);
    accNext = macEn ? (acc + prod) : acc;
    satVal  = accNext[15:0];
    satNext = 1'b0;
    if (accNext > 32'sd32767) begin
      satVal  = 16'h7FFF;
      satNext = 1'b1;
    end else if (accNext < -32'sd32768) begin
      satVal  = 16'h8000;
      satNext = 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN: begin
        if (!iACC_en)                nextState = IDLE;
        else if (runCnt <= 5'd1)     nextState = DONE;
      end
      DONE:    if (!iACC_en) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rdMux = 16'h0000;
    if (iBusAddr[7:4] == 4'h0) begin
      rdMux = aBuf[iBusAddr[3:0]];
    end else if (iBusAddr[7:4] == 4'h1) begin
      rdMux = wBuf[iBusAddr[3:0]];
    end else begin
      case (iBusAddr)
        8'h20:   rdMux = {11'd0, lenReg};
        8'h21:   rdMux = result;
        8'h22:   rdMux = {13'd0, satFlag, oBusy, oACC_done};
        default: rdMux = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prevEn    <= 1'b0;
      armed     <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      runCnt    <= '0;
      result    <= '0;
      satFlag   <= 1'b0;
      lenReg    <= '0;
      oBusRData <= '0;
    end else begin
      state  <= nextState;
      prevEn <= iACC_en;
      armed  <= armed | !iACC_en;
      if (start) begin
        acc     <= '0;
        idx     <= '0;
        satFlag <= 1'b0;
        runCnt  <= lenReg;
      end else if (macEn) begin
        acc    <= accNext;
        idx    <= idx + 4'd1;
        runCnt <= runCnt - 5'd1;
      end
      if (finish) begin
        result  <= satVal;
        satFlag <= satNext;
      end
      if (wrIdle && (iBusAddr == 8'h20)) lenReg <= lenWr;
      // rdMux sees pre-write contents, so a same-cycle write+read returns old data
      if (iBusRead) oBusRData <= rdMux;
    end
  end

  always_ff @(posedge clk) begin
    if (wrIdle && (iBusAddr[7:5] == 3'b000)) begin
      if (iBusAddr[4]) wBuf[iBusAddr[3:0]] <= iBusWData;
      else             aBuf[iBusAddr[3:0]] <= iBusWData;
    end
  end

endmodule

// File: tb/tb_acc_mac_ctrl.sv
// Directed bench for acc_mac_ctrl: bus register access, MAC runs, saturation, abort and reset behaviour.
module tb_acc_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iACC_en = 1'b0;
  logic        oACC_done;
  logic        iBusWrite = 1'b0;
  logic        iBusRead = 1'b0;
  logic [7:0]  iBusAddr = 8'h00;
  logic [15:0] iBusWData = 16'h0000;
  logic [15:0] oBusRData;
  logic        oBusy;

  int checks = 0;
  int errors = 0;

  acc_mac_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .iACC_en   (iACC_en),
    .oACC_done (oACC_done),
    .iBusWrite (iBusWrite),
    .iBusRead  (iBusRead),
    .iBusAddr  (iBusAddr),
    .iBusWData (iBusWData),
    .oBusRData (oBusRData),
    .oBusy     (oBusy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [15:0] d);
    iBusWrite = 1'b1;
    iBusAddr  = a;
    iBusWData = d;
    tick();
    iBusWrite = 1'b0;
  endtask

  task automatic busRead(input logic [7:0] a, output logic [15:0] d);
    iBusRead = 1'b1;
    iBusAddr = a;
    tick();
    iBusRead = 1'b0;
    d = oBusRData;
  endtask

  task automatic runToDone(output int cyc);
    iACC_en = 1'b1;
    cyc = 0;
    while (!oACC_done && cyc < 40) begin
      tick();
      cyc++;
    end
    checkVal("done reached", oACC_done, 1);
  endtask

  task automatic dropEn();
    iACC_en = 1'b0;
    tick();
    checkVal("done falls", oACC_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int cyc;

    // reset state
    repeat (2) tick();
    checkVal("rst done", oACC_done, 0);
    checkVal("rst busy", oBusy, 0);
    checkVal("rst rdata", oBusRData, 0);
    rst = 1'b0;
    tick();
    busRead(8'h21, rd); checkVal("rst result", rd, 16'h0000);
    busRead(8'h20, rd); checkVal("rst len", rd, 16'h0000);
    busRead(8'h22, rd); checkVal("rst status", rd, 16'h0000);

    // basic 4-tap dot product: 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin
      busWrite(8'(i), 16'(i + 1));
      busWrite(8'(16 + i), 16'(i + 5));
    end
    busWrite(8'h20, 16'd4);
    iACC_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkVal($sformatf("len4 busy k%0d", k), oBusy, (k <= 4) ? 1 : 0);
      checkVal($sformatf("len4 done k%0d", k), oACC_done, (k == 5) ? 1 : 0);
    end
    busRead(8'h21, rd); checkVal("len4 result", rd, 16'd70);
    busRead(8'h22, rd); checkVal("len4 status", rd, 16'h0001);
    dropEn();
    busRead(8'h22, rd); checkVal("idle status", rd, 16'h0000);

    // abort after 5 RUN cycles, then full restart: A=1, W=i -> sum 0..15 = 120
    for (int i = 0; i < 16; i++) begin
      busWrite(8'(i), 16'd1);
      busWrite(8'(16 + i), 16'(i));
    end
    busWrite(8'h20, 16'd16);
    iACC_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkVal($sformatf("abort busy k%0d", k), oBusy, 1);
      checkVal($sformatf("abort done k%0d", k), oACC_done, 0);
    end
    iACC_en = 1'b0;
    tick();
    checkVal("abort idle busy", oBusy, 0);
    checkVal("abort idle done", oACC_done, 0);
    busRead(8'h21, rd); checkVal("abort result kept", rd, 16'd70);
    busRead(8'h22, rd); checkVal("abort status", rd, 16'h0000);
    runToDone(cyc);
    checkVal("len16 latency", cyc, 17);
    busRead(8'h21, rd); checkVal("len16 result", rd, 16'd120);
    dropEn();

    // writes dropped during RUN, reads allowed
    iACC_en = 1'b1;
    tick();
    busWrite(8'h00, 16'h1234);
    busWrite(8'h20, 16'd3);
    busRead(8'h22, rd); checkVal("run status", rd, 16'h0002);
    runToDone(cyc);
    busRead(8'h21, rd); checkVal("run-write result", rd, 16'd120);
    dropEn();
    busRead(8'h00, rd); checkVal("A0 not written", rd, 16'h0001);
    busRead(8'h20, rd); checkVal("len not written", rd, 16'd16);
    iBusWrite = 1'b1; iBusRead = 1'b1; iBusAddr = 8'h20; iBusWData = 16'd5;
    tick();
    iBusWrite = 1'b0; iBusRead = 1'b0;
    checkVal("wr+rd old len", oBusRData, 16'd16);
    busRead(8'h20, rd); checkVal("len now 5", rd, 16'd5);
    busWrite(8'h21, 16'hBEEF);
    busRead(8'h21, rd); checkVal("result read-only", rd, 16'd120);
    busWrite(8'h30, 16'hFFFF);
    busRead(8'h30, rd); checkVal("unmapped read", rd, 16'h0000);
    busWrite(8'h20, 16'd31);
    busRead(8'h20, rd); checkVal("len clamp", rd, 16'd16);

    // positive and negative saturation
    busWrite(8'h00, 16'h7FFF); busWrite(8'h01, 16'h7FFF);
    busWrite(8'h10, 16'h7FFF); busWrite(8'h11, 16'h7FFF);
    busWrite(8'h20, 16'd2);
    runToDone(cyc);
    checkVal("len2 latency", cyc, 3);
    busRead(8'h21, rd); checkVal("sat pos result", rd, 16'h7FFF);
    busRead(8'h22, rd); checkVal("sat pos status", rd, 16'h0005);
    dropEn();
    busWrite(8'h00, 16'h8001); busWrite(8'h01, 16'h8001);
    runToDone(cyc);
    busRead(8'h21, rd); checkVal("sat neg result", rd, 16'h8000);
    busRead(8'h22, rd); checkVal("sat neg status", rd, 16'h0005);
    dropEn();

    // LEN=0: one RUN cycle, no MAC
    busWrite(8'h20, 16'd0);
    iACC_en = 1'b1;
    tick();
    checkVal("len0 busy", oBusy, 1);
    checkVal("len0 done k1", oACC_done, 0);
    tick();
    checkVal("len0 done k2", oACC_done, 1);
    checkVal("len0 busy k2", oBusy, 0);
    busRead(8'h21, rd); checkVal("len0 result", rd, 16'h0000);
    busRead(8'h22, rd); checkVal("len0 status", rd, 16'h0001);
    dropEn();

    // reset with iACC_en held high: no start until a fresh rise
    iACC_en = 1'b1;
    repeat (2) tick();
    checkVal("pre-rst done", oACC_done, 1);
    rst = 1'b1;
    #2;
    checkVal("async rst done", oACC_done, 0);
    checkVal("async rst busy", oBusy, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal($sformatf("held en no start %0d", k), oBusy, 0);
    end
    iACC_en = 1'b0;
    tick();
    iACC_en = 1'b1;
    tick();
    checkVal("fresh rise start", oBusy, 1);
    rst = 1'b1;
    #2;
    checkVal("mid-run rst busy", oBusy, 0);
    tick();
    rst = 1'b0;
    iACC_en = 1'b0;
    tick();
    busRead(8'h21, rd); checkVal("post-rst result", rd, 16'h0000);
    busRead(8'h22, rd); checkVal("post-rst status", rd, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
